lcd_ctrl: RTL and testbench

- Hardware timing engine for the HD44780-style character LCD on the board's LCD header.
- Receives byte-wide commands and characters over a valid/ready handshake from the memory-mapped I/O side of the load/store path.
- Generates the LCD bus sequence for each byte: RS and DATA setup, the EN pulse, hold, then a per-command settle time. Software no longer bit-bangs EN.
- Sits between the I/O register bank and the top-level LCD pins.

---
 rtl/lcd_pkg.sv | 43 ++++
 rtl/lcd_timer.sv | 28 ++
 rtl/lcd_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character LCD controller: FSM states,
// power-on init command bytes and small helpers used at elaboration/runtime.
package lcd_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_PULSE = 3'd2,
      S_HOLD  = 3'd3,
      S_WAIT  = 3'd4,
      S_PWRUP = 3'd5,
      S_INIT  = 3'd6
   } lcd_state_t;

   localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
   localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;

   localparam int INIT_LEN = 4;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Power-on init ROM, issued in index order.
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      logic [7:0] cmd;
      case (idx)
         2'd0:    cmd = LCD_CMD_FUNC_SET;
         2'd1:    cmd = LCD_CMD_DISP_ON;
         2'd2:    cmd = LCD_CMD_CLEAR;
         default: cmd = LCD_CMD_ENTRY;
      endcase
      return cmd;
   endfunction

   // Clear (0x01) and Return Home (0x02/0x03) instructions need the long settle.
   function automatic logic needs_clr_wait(input logic rs, input logic [7:0] data);
      return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed state of the LCD controller.
// A load value of zero is stretched to one cycle; done marks the final cycle.
module lcd_timer #(
   parameter int             W       = 8,
   parameter logic [W-1:0]   RST_VAL = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [W-1:0]  load_val,
   output logic          done
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= RST_VAL;
      end else if (load) begin
         count_reg <= (load_val == '0) ? W'(1) : load_val;
      end else if (count_reg > W'(1)) begin
         count_reg <= count_reg - W'(1);
      end
   end

   assign done = (count_reg <= W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 bus timing engine: one byte per handshake, setup/EN/hold/settle.
// Define LCD_INIT_EN to run the power-on delay and init sequence in hardware.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int T_SETUP    = 2,
   parameter int T_EN_HIGH  = 12,
   parameter int T_HOLD     = 2,
   parameter int T_CMD_WAIT = 2000,
   parameter int T_CLR_WAIT = 82000,
   parameter int T_PWRUP    = 750000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_cmd_vld,
   input  logic        i_cmd_rs,
   input  logic [7:0]  i_cmd_data,
   output logic        o_cmd_rdy,
   output logic        o_init_done,
   output logic        o_lcd_on,
   output logic        o_lcd_en,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic [7:0]  o_lcd_data
);

   localparam int MAX_T = max_int(max_int(max_int(T_SETUP, T_EN_HIGH), max_int(T_HOLD, T_CMD_WAIT)),
                                  max_int(max_int(T_CLR_WAIT, T_PWRUP), 1));
   localparam int CNT_W = $clog2(MAX_T + 1);

   localparam logic [CNT_W-1:0] LD_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP);
   localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN_HIGH);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD);
   localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD_WAIT);
   localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR_WAIT);

`ifdef LCD_INIT_EN
   localparam lcd_state_t       RST_STATE = S_PWRUP;
   localparam logic [CNT_W-1:0] RST_CNT   = CNT_W'(T_PWRUP);
`else
   localparam lcd_state_t       RST_STATE = S_IDLE;
   localparam logic [CNT_W-1:0] RST_CNT   = LD_ONE;
`endif

   lcd_state_t        state_reg, state_next;
   logic              rdy_reg, rdy_next;
   logic              done_reg, done_next;
   logic              on_reg;
   logic              en_reg, en_next;
   logic              rs_reg, rs_next;
   logic [7:0]        data_reg, data_next;
   logic              long_wait_reg, long_wait_next;
   logic              timer_load;
   logic [CNT_W-1:0]  timer_val;
   logic              timer_done;

`ifdef LCD_INIT_EN
   logic [2:0]        init_idx_reg, init_idx_next;
`endif

   lcd_timer #(
      .W       (CNT_W),
      .RST_VAL (RST_CNT)
   ) u_timer (
      .clk      (i_clk),
      .rst      (i_rst),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

   always_comb begin
      state_next     = state_reg;
      timer_load     = 1'b0;
      timer_val      = LD_ONE;
      rs_next        = rs_reg;
      data_next      = data_reg;
      long_wait_next = long_wait_reg;
`ifdef LCD_INIT_EN
      init_idx_next  = init_idx_reg;
`endif
      case (state_reg)
         S_IDLE: begin
            if (i_cmd_vld && rdy_reg) begin
               rs_next        = i_cmd_rs;
               data_next      = i_cmd_data;
               long_wait_next = needs_clr_wait(i_cmd_rs, i_cmd_data);
               state_next     = S_SETUP;
               timer_load     = 1'b1;
               timer_val      = LD_SETUP;
            end
         end
         S_SETUP: begin
            if (timer_done) begin
               state_next = S_PULSE;
               timer_load = 1'b1;
               timer_val  = LD_EN;
            end
         end
         S_PULSE: begin
            if (timer_done) begin
               state_next = S_HOLD;
               timer_load = 1'b1;
               timer_val  = LD_HOLD;
            end
         end
         S_HOLD: begin
            if (timer_done) begin
               state_next = S_WAIT;
               timer_load = 1'b1;
               timer_val  = long_wait_reg ? LD_CLR : LD_CMD;
            end
         end
         S_WAIT: begin
            if (timer_done) begin
               timer_load = 1'b1;
               timer_val  = LD_ONE;
`ifdef LCD_INIT_EN
               state_next = (init_idx_reg == 3'(INIT_LEN)) ? S_IDLE : S_INIT;
`else
               state_next = S_IDLE;
`endif
            end
         end
`ifdef LCD_INIT_EN
         S_PWRUP: begin
            if (timer_done) begin
               state_next = S_INIT;
               timer_load = 1'b1;
               timer_val  = LD_ONE;
            end
         end
         // INIT is the hardware counterpart of an IDLE accept cycle.
         S_INIT: begin
            rs_next        = 1'b0;
            data_next      = init_cmd(init_idx_reg[1:0]);
            long_wait_next = needs_clr_wait(1'b0, init_cmd(init_idx_reg[1:0]));
            init_idx_next  = init_idx_reg + 3'd1;
            state_next     = S_SETUP;
            timer_load     = 1'b1;
            timer_val      = LD_SETUP;
         end
`endif
         default: begin
            state_next = S_IDLE;
            timer_load = 1'b1;
            timer_val  = LD_ONE;
         end
      endcase

      rdy_next = (state_next == S_IDLE);
      en_next  = (state_next == S_PULSE);
`ifdef LCD_INIT_EN
      done_next = done_reg | (state_next == S_IDLE);
`else
      done_next = 1'b1;
`endif
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg     <= RST_STATE;
         rdy_reg       <= 1'b0;
         done_reg      <= 1'b0;
         on_reg        <= 1'b0;
         en_reg        <= 1'b0;
         rs_reg        <= 1'b0;
         data_reg      <= 8'h00;
         long_wait_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         rdy_reg       <= rdy_next;
         done_reg      <= done_next;
         on_reg        <= 1'b1;
         en_reg        <= en_next;
         rs_reg        <= rs_next;
         data_reg      <= data_next;
         long_wait_reg <= long_wait_next;
      end
   end

`ifdef LCD_INIT_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         init_idx_reg <= 3'd0;
      end else begin
         init_idx_reg <= init_idx_next;
      end
   end
`endif

   assign o_cmd_rdy   = rdy_reg;
   assign o_init_done = done_reg;
   assign o_lcd_on    = on_reg;
   assign o_lcd_en    = en_reg;
   assign o_lcd_rs    = rs_reg;
   assign o_lcd_rw    = 1'b0;
   assign o_lcd_data  = data_reg;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: directed timing checks plus random traffic
// compared every cycle against a schedule-based model. Honours LCD_INIT_EN.
module tb_lcd_ctrl;

   localparam int TS = 1, TE = 2, TH = 1, TCMD = 4, TCLR = 10, TPWR = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vld = 1'b0;
   logic       cmd_rs = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_rdy, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw;
   logic [7:0] lcd_data;

   lcd_ctrl #(
      .T_SETUP(TS), .T_EN_HIGH(TE), .T_HOLD(TH),
      .T_CMD_WAIT(TCMD), .T_CLR_WAIT(TCLR), .T_PWRUP(TPWR)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_cmd_vld(vld), .i_cmd_rs(cmd_rs), .i_cmd_data(cmd_data),
      .o_cmd_rdy(cmd_rdy), .o_init_done(init_done), .o_lcd_on(lcd_on), .o_lcd_en(lcd_en),
      .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_data(lcd_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // ---------------- behavioural model: a schedule of bytes on the bus ----------------
   typedef struct { int n; logic rs; logic [7:0] d; } send_t;
   send_t sends[$];
   int    cyc = 0;
   int    rdy_at = 0;
   int    done_at = 0;
   bit    started = 0;
   bit    exp_rdy = 0, exp_done = 0, exp_on = 0, exp_en = 0, exp_rs = 0;
   logic [7:0] exp_data = 8'h00;

`ifdef LCD_INIT_EN
   logic [7:0] init_seq [4];
   initial begin
      init_seq[0] = 8'h38; init_seq[1] = 8'h0C; init_seq[2] = 8'h01; init_seq[3] = 8'h06;
   end
`endif

   function automatic int settle(input logic rs, input logic [7:0] d);
      int w;
      w = (!rs && d >= 8'd1 && d <= 8'd3) ? TCLR : TCMD;
      return (w < 1) ? 1 : w;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         started = 0;
         sends.delete();
         exp_rdy = 0; exp_done = 0; exp_on = 0; exp_en = 0; exp_rs = 0; exp_data = 8'h00;
         cyc++;
      end else begin
         bit    acc;
         send_t s;
         acc = started && exp_rdy && vld;
         cyc++;
         if (!started) begin
            started = 1;
`ifdef LCD_INIT_EN
            begin
               int n;
               n = cyc - 1 + TPWR;
               for (int i = 0; i < 4; i++) begin
                  s.n = n; s.rs = 1'b0; s.d = init_seq[i];
                  sends.push_back(s);
                  n += 1 + TS + TE + TH + settle(1'b0, init_seq[i]);
               end
               rdy_at = n;
            end
`else
            rdy_at = cyc;
`endif
            done_at = rdy_at;
         end
         if (acc) begin
            s.n = cyc - 1; s.rs = cmd_rs; s.d = cmd_data;
            sends.push_back(s);
            rdy_at = cyc + TS + TE + TH + settle(cmd_rs, cmd_data);
            $display("tx accept cyc=%0d rs=%0b data=%02h rdy_again=%0d", cyc - 1, cmd_rs, cmd_data, rdy_at);
         end
         exp_on   = 1;
         exp_rdy  = (cyc >= rdy_at);
         exp_done = (cyc >= done_at);
         exp_en = 0; exp_rs = 0; exp_data = 8'h00;
         foreach (sends[i]) begin
            if (sends[i].n + 1 <= cyc) begin
               exp_rs   = sends[i].rs;
               exp_data = sends[i].d;
            end
            if (cyc >= sends[i].n + 1 + TS && cyc <= sends[i].n + TS + TE) exp_en = 1;
         end
      end
   end

   // ---------------- per-cycle compare and EN pulse log ----------------
   typedef struct { int c; logic rs; logic [7:0] d; } pulse_t;
   pulse_t pulse_log[$];
   int     ncyc = 0;
   int     unstable = 0;
   logic       prev_en = 1'b0, prev_rs = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(negedge clk) begin
      pulse_t p;
      ncyc++;
      chk("cmp_rdy",  cmd_rdy,   exp_rdy);
      chk("cmp_done", init_done, exp_done);
      chk("cmp_on",   lcd_on,    exp_on);
      chk("cmp_en",   lcd_en,    exp_en);
      chk("cmp_rs",   lcd_rs,    exp_rs);
      chk("cmp_rw",   lcd_rw,    1'b0);
      chk("cmp_data", lcd_data,  exp_data);
      if (lcd_en && !prev_en) begin
         p.c = ncyc; p.rs = lcd_rs; p.d = lcd_data;
         pulse_log.push_back(p);
      end
      if (lcd_en && prev_en && (lcd_data !== prev_data || lcd_rs !== prev_rs)) unstable++;
      prev_en = lcd_en; prev_rs = lcd_rs; prev_data = lcd_data;
   end

   // ---------------- directed helpers ----------------
   task automatic accept_byte(input logic rs, input logic [7:0] d, input bit drop);
      int i;
      @(negedge clk);
      vld = 1'b1; cmd_rs = rs; cmd_data = d;
      for (i = 0; i < 200; i++) begin
         if (cmd_rdy) break;
         @(negedge clk);
      end
      if (i == 200) chk("accept_timeout", cmd_rdy, 1'b1);
      @(posedge clk); #1;
      if (drop) vld = 1'b0;
   endtask

   task automatic send_byte(input logic rs, input logic [7:0] d, output int en_k, output int rdy_k);
      accept_byte(rs, d, 1'b1);
      chk("latched_data", lcd_data, d);
      chk("latched_rs", lcd_rs, rs);
      en_k = -1; rdy_k = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (lcd_en && en_k < 0) en_k = k;
         if (cmd_rdy) begin
            rdy_k = k;
            break;
         end
      end
   endtask

   task automatic wait_rdy(input string name);
      int i;
      for (i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (cmd_rdy) break;
      end
      if (i == 300) chk(name, cmd_rdy, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int en_k, rdy_k, base;
      bit rdy_prev;

      repeat (3) @(negedge clk);
      chk("rst_rdy",  cmd_rdy,   1'b0);
      chk("rst_done", init_done, 1'b0);
      chk("rst_on",   lcd_on,    1'b0);
      chk("rst_en",   lcd_en,    1'b0);
      chk("rst_rs",   lcd_rs,    1'b0);
      chk("rst_rw",   lcd_rw,    1'b0);
      chk("rst_data", lcd_data,  8'h00);
      rst = 1'b0;

`ifdef LCD_INIT_EN
      begin
         int k;
         pulse_log.delete();
         vld = 1'b1; cmd_rs = 1'b1; cmd_data = 8'hAA;
         for (k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (cmd_rdy) break;
         end
         vld = 1'b0;
         chk("init_rdy_cycle", k, 62);
         chk("init_done_with_rdy", init_done, 1'b1);
         chk("init_pulses", pulse_log.size(), 4);
         for (int i = 0; i < 4 && i < pulse_log.size(); i++) begin
            chk("init_byte", pulse_log[i].d, init_seq[i]);
            chk("init_rs", pulse_log[i].rs, 1'b0);
         end
      end
`else
      @(posedge clk); #1;
      chk("post_rst_rdy",  cmd_rdy,   1'b1);
      chk("post_rst_on",   lcd_on,    1'b1);
      chk("post_rst_done", init_done, 1'b1);
`endif

      send_byte(1'b1, 8'h41, en_k, rdy_k);
      chk("char_en_rise", en_k, 1);
      chk("char_rdy_back", rdy_k, 8);
      send_byte(1'b0, 8'h01, en_k, rdy_k);
      chk("clear_rdy_back", rdy_k, 14);
      send_byte(1'b1, 8'h01, en_k, rdy_k);
      chk("char01_rdy_back", rdy_k, 8);

      // back-to-back with valid held high
      pulse_log.delete();
      base = unstable;
      accept_byte(1'b1, 8'h48, 1'b0);
      accept_byte(1'b1, 8'h49, 1'b1);
      repeat (12) @(negedge clk);
      chk("b2b_pulses", pulse_log.size(), 2);
      if (pulse_log.size() == 2) begin
         chk("b2b_byte0", pulse_log[0].d, 8'h48);
         chk("b2b_byte1", pulse_log[1].d, 8'h49);
         chk("b2b_spacing", pulse_log[1].c - pulse_log[0].c, 9);
      end
      chk("b2b_data_stable", unstable - base, 0);

      // reset while EN is high
      accept_byte(1'b1, 8'h55, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (lcd_en) break;
      end
      chk("pre_rst_en", lcd_en, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_en", lcd_en, 1'b0);
      chk("mid_rst_data", lcd_data, 8'h00);
      chk("mid_rst_rdy", cmd_rdy, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
`ifdef LCD_INIT_EN
      wait_rdy("reinit_timeout");
`else
      @(posedge clk); #1;
      chk("rerelease_rdy", cmd_rdy, 1'b1);
`endif
      send_byte(1'b1, 8'h5A, en_k, rdy_k);
      chk("after_rst_en_rise", en_k, 1);
      chk("after_rst_rdy_back", rdy_k, 8);

      // random traffic, per-cycle compare does the checking
      rdy_prev = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (!vld || rdy_prev) begin
            vld      = ($urandom_range(0, 3) != 0);
            cmd_rs   = 1'($urandom_range(0, 1));
            cmd_data = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         end
         rdy_prev = cmd_rdy;
      end
      @(negedge clk);
      vld = 1'b0;
      repeat (20) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
